// File: rtl/tiger_muldiv_unit.sv
// tiger_muldiv_unit
//   Iterative MIPS multiply/divide unit with HI/LO registers. It sits in the
//   execute stage and holds its instruction there, through stallRq, until the
//   product or quotient/remainder has been committed to HI/LO.
//
//   Optional feature macro: TIGER_MULDIV_FASTMUL_EN
//     When defined, MULT/MULTU complete in one cycle through an array
//     multiplier and stall only in the start cycle. DIV/DIVU stay iterative.
//
// Ports
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   valid muldiv op in execute
//   op       in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 ignored
//   opA      in   forwarded rs value
//   opB      in   forwarded rt value
//   stallEx  in   execute stage stalled
//   clearEx  in   execute stage bubble, op is void this cycle
//   stallRq  out  stall request to the stall logic (combinational)
//   busy     out  iterating (CALC)
//   hi, lo   out  HI / LO registers
//
// state | meaning
// IDLE  | waiting for an op; latches operands on a long op
// CALC  | one multiply/divide iteration per cycle
// DONE  | result committed; hold until the instruction leaves execute
module tiger_muldiv_unit #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        stallEx,
  input  logic        clearEx,
  output logic        stallRq,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(DIV_ITERS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [63:0]   acc;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0]   divisor;  // multiplicand magnitude or divisor magnitude
  logic          isDiv;
  logic          resNeg;
  logic          remNeg;
  logic          divZero;

  logic        go;
  logic        isLong;
  logic        isDivOp;
  logic        isSigned;
  logic [31:0] magA;
  logic [31:0] magB;

  assign go       = start && !clearEx;
  assign isLong   = !op[2];
  assign isDivOp  = op[1];
  assign isSigned = !op[0];
  assign magA     = (isSigned && opA[31]) ? -opA : opA;
  assign magB     = (isSigned && opB[31]) ? -opB : opB;

  assign stallRq = ((state == IDLE) && go && isLong) || (state == CALC);
  assign busy    = (state == CALC);

`ifdef TIGER_MULDIV_FASTMUL_EN
  logic signed [32:0] fastA;
  logic signed [32:0] fastB;
  logic signed [65:0] fastFull;
  assign fastA    = {isSigned & opA[31], opA};
  assign fastB    = {isSigned & opB[31], opB};
  assign fastFull = fastA * fastB;
`endif

  // One iteration step. With a zero divisor every trial subtract succeeds,
  // so the quotient fills with ones and the remainder rebuilds the dividend
  // magnitude; after sign correction HI therefore equals opA.
  logic [32:0] mulSum;
  logic [32:0] remShift;
  logic [33:0] diff;
  logic [63:0] accNext;
  logic [63:0] prodFinal;
  logic [31:0] quoFinal;
  logic [31:0] remFinal;

  always_comb begin
    mulSum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? divisor : 32'd0)};
    remShift = {acc[63:32], acc[31]};
    diff     = {1'b0, remShift} - {2'b00, divisor};
    accNext  = {mulSum, acc[31:1]};
    if (isDiv) begin
      if (!diff[33]) accNext = {diff[31:0], acc[30:0], 1'b1};
      else           accNext = {remShift[31:0], acc[30:0], 1'b0};
    end
    prodFinal = resNeg ? -accNext : accNext;
    quoFinal  = divZero ? 32'hFFFF_FFFF : (resNeg ? -accNext[31:0] : accNext[31:0]);
    remFinal  = remNeg ? -accNext[63:32] : accNext[63:32];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      divisor <= '0;
      isDiv   <= 1'b0;
      resNeg  <= 1'b0;
      remNeg  <= 1'b0;
      divZero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go && isLong) begin
`ifdef TIGER_MULDIV_FASTMUL_EN
            if (!isDivOp) begin
              {hi, lo} <= fastFull[63:0];
              state    <= DONE;
            end else begin
`else
            begin
`endif
              acc     <= {32'd0, (isDivOp ? magA : magB)};
              divisor <= isDivOp ? magB : magA;
              isDiv   <= isDivOp;
              resNeg  <= isSigned && (opA[31] ^ opB[31]);
              remNeg  <= isSigned && isDivOp && opA[31];
              divZero <= isDivOp && (opB == 32'd0);
              count   <= '0;
              state   <= CALC;
            end
          end else if (go && op == 3'd4) begin
            hi    <= opA;
            state <= DONE;
          end else if (go && op == 3'd5) begin
            lo    <= opA;
            state <= DONE;
          end
        end
        CALC: begin
          acc   <= accNext;
          count <= count + 1'b1;
          if (count == LAST_ITER) begin
            if (isDiv) begin
              lo <= quoFinal;
              hi <= remFinal;
            end else begin
              {hi, lo} <= prodFinal;
            end
            state <= DONE;
          end
        end
        DONE: begin
          // Same instruction is still in execute while stalled; do not restart.
          if (!stallEx) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tiger_muldiv_unit.sv
module tb_tiger_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        stallEx;
  logic        clearEx;
  logic        stallRq;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  tiger_muldiv_unit #(.DIV_ITERS(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .opA(opA), .opB(opB),
    .stallEx(stallEx), .clearEx(clearEx), .stallRq(stallRq), .busy(busy),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

`ifdef TIGER_MULDIV_FASTMUL_EN
  localparam int MUL_RQ   = 1;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_RQ   = 33;
  localparam int MUL_BUSY = 32;
`endif

  typedef struct {
    string       nm;
    int          kind;      // 0: no stall, result next cycle; 1: stalling op
    int          issueCyc;
    logic [31:0] eHi;
    logic [31:0] eLo;
    int          eRq;
    int          eBusy;
  } entry_t;

  entry_t sbq[$];
  int     nCompared   = 0;
  int     nMismatched = 0;
  int     doneCnt     = 0;
  int     cyc         = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the head entry when the DUT presents its result.
  initial begin
    entry_t e;
    bit prevRq;
    int rqCnt;
    int busyCnt;
    prevRq = 1'b0;
    rqCnt = 0;
    busyCnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prevRq = 1'b0;
        rqCnt = 0;
        busyCnt = 0;
      end else begin
        if (stallRq) rqCnt++;
        if (busy) busyCnt++;
        if (sbq.size() > 0) begin
          e = sbq[0];
          if (e.kind == 0) begin
            if (cyc == e.issueCyc) begin
              chk({e.nm, "_nostall"}, 64'(stallRq), 64'd0);
            end else if (cyc == e.issueCyc + 1) begin
              chk({e.nm, "_hi"}, 64'(hi), 64'(e.eHi));
              chk({e.nm, "_lo"}, 64'(lo), 64'(e.eLo));
              void'(sbq.pop_front());
              doneCnt++;
              rqCnt = 0;
              busyCnt = 0;
            end
          end else if (prevRq && !stallRq) begin
            chk({e.nm, "_hi"}, 64'(hi), 64'(e.eHi));
            chk({e.nm, "_lo"}, 64'(lo), 64'(e.eLo));
            chk({e.nm, "_stallcycles"}, 64'(rqCnt), 64'(e.eRq));
            chk({e.nm, "_busycycles"}, 64'(busyCnt), 64'(e.eBusy));
            void'(sbq.pop_front());
            doneCnt++;
            rqCnt = 0;
            busyCnt = 0;
          end
        end
        prevRq = stallRq;
      end
    end
  end

  task automatic issue(input string nm, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit ce, input logic [31:0] eHi,
                       input logic [31:0] eLo, input bit hold);
    entry_t e;
    int d0;
    @(posedge clk); #1;
    d0 = doneCnt;
    start = 1'b1; op = o; opA = a; opB = b; clearEx = ce; stallEx = hold;
    e.nm = nm;
    e.kind = (!ce && o < 3'd4) ? 1 : 0;
    e.issueCyc = cyc;
    e.eHi = eHi;
    e.eLo = eLo;
    e.eRq = (o[1]) ? 33 : MUL_RQ;
    e.eBusy = (o[1]) ? 32 : MUL_BUSY;
    sbq.push_back(e);
    @(posedge clk); #1;
    if (!hold) begin
      start = 1'b0;
      clearEx = 1'b0;
    end
    for (int i = 0; i < 80 && doneCnt == d0; i++) begin
      @(negedge clk); #1;
    end
    if (doneCnt == d0) begin
      nCompared++;
      nMismatched++;
      $display("FAIL %s_timeout: got no result expected result within 80 cycles", nm);
      sbq.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 3'd0; opA = '0; opB = '0;
    stallEx = 1'b0; clearEx = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_stallRq", 64'(stallRq), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);

    issue("multu_max",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    issue("mult_neg",    3'd0, 32'hFFFFFFFD, 32'd7,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    issue("mult_minsq",  3'd0, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000, 1'b0);
    issue("multu_small", 3'd1, 32'h12345678, 32'h10,       1'b0, 32'h00000001, 32'h23456780, 1'b0);
    issue("div_neg",     3'd2, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    issue("div_negdvs",  3'd2, 32'd7,        32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    issue("divu_zero",   3'd3, 32'd100,      32'd0,        1'b0, 32'd100,      32'hFFFFFFFF, 1'b0);
    issue("div_zero",    3'd2, 32'hFFFFFFF9, 32'd0,        1'b0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);
    issue("div_ovf",     3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000, 1'b0);
    issue("divu_big",    3'd3, 32'hFFFFFFFF, 32'h10,       1'b0, 32'h0000000F, 32'h0FFFFFFF, 1'b0);

    // Instruction held in execute: start and stallEx stay high after DONE.
    issue("divu_held",   3'd3, 32'd1000,     32'd7,        1'b0, 32'd6,        32'h8E,       1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("held_stallRq", 64'(stallRq), 64'd0);
      chk("held_busy", 64'(busy), 64'd0);
      chk("held_hi", 64'(hi), 64'd6);
      chk("held_lo", 64'(lo), 64'h8E);
    end
    @(posedge clk); #1;
    start = 1'b0;
    stallEx = 1'b0;
    issue("multu_after", 3'd1, 32'd3,        32'd5,        1'b0, 32'd0,        32'd15,       1'b0);

    issue("cleared",     3'd0, 32'd5,        32'd5,        1'b1, 32'd0,        32'd15,       1'b0);
    issue("op6",         3'd6, 32'd9,        32'd9,        1'b0, 32'd0,        32'd15,       1'b0);

    // Reset during CALC iteration 10.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd3; opA = 32'd12345; opB = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midreset_stallRq", 64'(stallRq), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_hi", 64'(hi), 64'd0);
    chk("midreset_lo", 64'(lo), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    issue("mthi",        3'd4, 32'h1234,     32'd0,        1'b0, 32'h1234,     32'd0,        1'b0);
    issue("mtlo",        3'd5, 32'hABCD,     32'd0,        1'b0, 32'h1234,     32'hABCD,     1'b0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
